// File: rtl/adder_serial_pkg.sv
// adder_serial_pkg: shared types and constants for the digit-serial adder
package adder_serial_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} adder_serial_state_t;
  localparam int ADDER_DIGIT = 4;
  function automatic int digit_count(input int w, input int d);
    return w / d;
  endfunction
endpackage

// File: rtl/adder_digit.sv
// adder_digit: combinational digit-wide adder with carry in/out
module adder_digit #(
  parameter int digit = 4
) (
  input  logic [digit-1:0] a,
  input  logic [digit-1:0] b,
  input  logic             cin,
  output logic [digit-1:0] s,
  output logic             cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + (digit+1)'(cin);
endmodule

// File: rtl/adder_digit_serial_16.sv
// adder_digit_serial_16: digit-serial adder, LSD first; define ADDER_SERIAL_SUB_EN for subtract
module adder_digit_serial_16
  import adder_serial_pkg::*;
#(
  parameter int width = 16,
  parameter int digit = ADDER_DIGIT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
`ifdef ADDER_SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [width-1:0] s,
  output logic             cout
);
  localparam int N = digit_count(width, digit);
  localparam int CW = $clog2(N + 1);
  adder_serial_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d;
  logic [width-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [width-digit-1:0] acc_q, acc_d;
  logic cout_q, cout_d;
  logic [digit-1:0] dsum;
  logic dcout, accept, last, sub_w;
`ifdef ADDER_SERIAL_SUB_EN
  assign sub_w = sub;
`else
  assign sub_w = 1'b0;
`endif
  assign accept = state_q != RUN && start;
  assign last = cnt_q == CW'(N - 1);
  adder_digit #(.digit(digit)) u_digit (
    .a   (a_q[digit-1:0]),
    .b   (b_q[digit-1:0]),
    .cin (carry_q),
    .s   (dsum),
    .cout(dcout)
  );
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  // next state: DONE accepts a new start exactly like IDLE
  always_comb begin
    state_d = accept ? RUN : state_q;
    if (!accept && state_q == RUN) state_d = last ? DONE : RUN;
    if (!accept && state_q == DONE) state_d = IDLE;
  end
  // datapath next values: capture on accept, one digit per RUN cycle, publish on last digit
  always_comb begin
    cnt_d = cnt_q;
    carry_d = carry_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    s_d = s_q;
    cout_d = cout_q;
    if (accept) begin
      cnt_d = '0;
      carry_d = sub_w;
      a_d = a;
      b_d = sub_w ? ~b : b;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + CW'(1);
      carry_d = dcout;
      a_d = a_q >> digit;
      b_d = b_q >> digit;
      acc_d = (width-digit)'({dsum, acc_q} >> digit);
      s_d = last ? {dsum, acc_q} : s_q;
      cout_d = last ? dcout : cout_q;
    end
  end
  // datapath registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt_q <= '0;
      carry_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      s_q <= '0;
      cout_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      carry_q <= carry_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      s_q <= s_d;
      cout_q <= cout_d;
    end
  // handshake outputs decoded from state
  always_comb begin
    busy = state_q == RUN;
    done = state_q == DONE;
  end
  assign s = s_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_adder_digit_serial_16.sv
// tb_adder_digit_serial_16: randomized and directed checks against an arithmetic model
module tb_adder_digit_serial_16;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, sub = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic busy, done, cout;
  logic [15:0] s;
  int passed = 0, total = 0;

  adder_digit_serial_16 dut (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b),
`ifdef ADDER_SERIAL_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .s(s), .cout(cout)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y, input logic sb);
    if (sb) return {x >= y, 16'(x - y)};
    return {1'b0, x} + {1'b0, y};
  endfunction

  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic isub,
                        output int cyc, output int nbusy, output int early);
    logic [15:0] s0;
    @(negedge clk);
    a = ia; b = ib; sub = isub; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'($urandom); b = 16'($urandom);
    cyc = 0; nbusy = 0; early = 0; s0 = s;
    while (!done && cyc < 20) begin
      if (busy) nbusy++;
      if (s !== s0) early = 1;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    #1;
    total++;
    if ({busy, done, cout, s} !== 19'd0) $display("FAIL reset: busy/done/cout/s=%b/%b/%b/%0d required 0", busy, done, cout, s);
    else passed++;
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic check_op(input string name, input logic [15:0] x, input logic [15:0] y, input logic sb);
    int cyc, nbusy, early;
    logic [16:0] exp;
    exp = model(x, y, sb);
    run_op(x, y, sb, cyc, nbusy, early);
    total++;
    if (cyc !== 4 || nbusy !== 4) $display("FAIL %s latency: done after %0d busy %0d required 4/4", name, cyc, nbusy);
    else passed++;
    total++;
    if ({cout, s} !== exp || done !== 1'b1 || busy !== 1'b0) $display("FAIL %s result: cout=%b s=%0d done=%b busy=%b required cout=%b s=%0d", name, cout, s, done, busy, exp[16], exp[15:0]);
    else passed++;
    total++;
    if (early !== 0) $display("FAIL %s partial: s changed before done, required stable", name);
    else passed++;
  endtask

  task automatic test_directed;
    check_op("add_980_722", 16'd980, 16'd722, 1'b0);
    check_op("wrap_65535_5", 16'd65535, 16'd5, 1'b0);
    check_op("carry_0fff_1", 16'h0FFF, 16'd1, 1'b0);
  endtask

  task automatic test_sub;
`ifdef ADDER_SERIAL_SUB_EN
    check_op("sub_980_722", 16'd980, 16'd722, 1'b1);
    check_op("sub_0_1", 16'd0, 16'd1, 1'b1);
    check_op("sub_65535_5", 16'd65535, 16'd5, 1'b1);
`endif
  endtask

  task automatic test_random;
    logic sb;
    for (int i = 0; i < 12; i++) begin
`ifdef ADDER_SERIAL_SUB_EN
      sb = 1'($urandom_range(0, 1));
`else
      sb = 1'b0;
`endif
      check_op("random", 16'($urandom), 16'($urandom), sb);
    end
  endtask

  task automatic test_back_to_back;
    int k;
    @(negedge clk);
    a = 16'd100; b = 16'd50; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'd1; b = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 20) begin @(negedge clk); k++; end
    total++;
    if (done !== 1'b1 || s !== 16'd150) $display("FAIL ignore_in_run: done=%b s=%0d required 1/150", done, s);
    else passed++;
    a = 16'd10001; b = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0) $display("FAIL b2b_accept: busy=%b done=%b required 1/0", busy, done);
    else passed++;
    k = 0;
    while (!done && k < 20) begin @(negedge clk); k++; end
    total++;
    if (k !== 4 || s !== 16'd10003 || cout !== 1'b0) $display("FAIL b2b_result: cycles=%0d s=%0d cout=%b required 4/10003/0", k, s, cout);
    else passed++;
  endtask

  task automatic test_hold;
    int cyc, nbusy, early;
    logic [16:0] exp;
    exp = model(16'd1234, 16'd4321, 1'b0);
    run_op(16'd1234, 16'd4321, 1'b0, cyc, nbusy, early);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a = 16'($urandom); b = 16'($urandom);
      total++;
      if ({cout, s} !== exp || done !== 1'b0) $display("FAIL hold: cout=%b s=%0d done=%b required %b/%0d/0", cout, s, done, exp[16], exp[15:0]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk);
    a = 16'd980; b = 16'd722; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++;
    if ({busy, done, cout, s} !== 19'd0) $display("FAIL reset_mid: busy/done/cout/s=%b/%b/%b/%0d required 0", busy, done, cout, s);
    else passed++;
    @(negedge clk) reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    total++;
    if (seen !== 0) $display("FAIL reset_mid_after: %0d busy/done cycles after release required 0", seen);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_sub;
    test_random;
    test_back_to_back;
    test_hold;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
